hand_swipe_detector: RTL
========================

# hand_swipe_detector

Per-frame gesture stage downstream of the skin-pixel centroid extractor. Once per video frame it takes the hand centroid column and the skin-pixel count. It smooths the position with a power-of-two moving average and runs a swipe-recognition FSM. It emits a filtered hand position for the game/paddle logic and one-cycle left/right swipe pulses.

## Interface
- `AVG_LOG2`, 2: log2 of moving-average window; window W = 4 frames.
- `MIN_PIXELS`, 200: minimum skin-pixel count for a frame to count as "hand present".
- `HOR_TOTAL`, 320: active width; `cent_x >= HOR_TOTAL` is invalid.
- `SWIPE_DIST`, 80: filtered displacement from anchor that constitutes a swipe.
- `SWIPE_FRAMES`, 8: valid frames in TRACK before re-anchoring.
- `COOLDOWN_FRAMES`, 15: frames ignored after a swipe.
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `frame_done` in 1: one-cycle strobe; `cent_x`/`pix_count` valid in that cycle.
- `cent_x` in 10: centroid column of skin pixels.
- `pix_count` in 17: skin pixels in frame (max 76800).
- `filt_x` out 10: moving-average position.
- `filt_valid` out 1: window fully populated with valid frames.
- `hand_present` out 1: last frame valid.
- `swipe_left` out 1: one-cycle pulse.
- `swipe_right` out 1: one-cycle pulse.
- `fsm_state` out 2: IDLE=0, TRACK=1, COOLDOWN=2 (debug/HEX display).

## Operation
- Frame valid when `pix_count >= MIN_PIXELS` and `cent_x < HOR_TOTAL`.
- Valid frame:
  - Shift `cent_x` into the W-entry history.
  - Update the running sum: sum = sum + cent_x − oldest entry. The sum is 10+AVG_LOG2 bits. Empty entries hold 0.
  - Fill counter saturates at W.
  - `filt_x` = sum_next >> AVG_LOG2 (truncating).
  - `filt_valid` = 1 once the fill counter reaches W.
- Invalid frame: clear history, sum, fill counter, `filt_valid`, `hand_present`. `filt_x` holds its last value.
- The FSM advances only on `filt_strobe` (`frame_done` delayed 1 cycle), using the just-updated `filt_x`/`filt_valid`.
- IDLE: if `filt_valid`, set anchor = `filt_x` and frame_cnt = 0, then go to TRACK.
- TRACK:
  - If `!filt_valid`, go to IDLE.
  - Otherwise frame_cnt++. Compare in 11-bit unsigned:
    - `filt_x >= anchor + SWIPE_DIST`: pulse `swipe_right`, go to COOLDOWN.
    - `anchor >= filt_x + SWIPE_DIST`: pulse `swipe_left`, go to COOLDOWN.
    - Else if frame_cnt == SWIPE_FRAMES: anchor = `filt_x`, frame_cnt = 0, stay in TRACK.
- COOLDOWN: count every `filt_strobe`, valid or not. After COOLDOWN_FRAMES strobes, go to IDLE. No swipe pulses in this state. Averaging continues.
- At most one swipe pulse per frame; left and right are never asserted together.

## Timing
- Reset values: `filt_x`=0, `filt_valid`=0, `hand_present`=0, `swipe_left`/`swipe_right`=0, `fsm_state`=IDLE. History, sum, anchor and counters are all 0.
- `filt_x`, `filt_valid`, `hand_present` update on the edge sampling `frame_done`, so they are visible 1 cycle later.
- Swipe pulses are registered on the `filt_strobe` edge: visible 2 cycles after `frame_done`, high for exactly 1 cycle.
- Back-to-back `frame_done` on consecutive cycles is fully supported. Throughput is one frame per cycle.
- `reset` asserted together with `frame_done`: reset wins and the sample is dropped.
- Reset mid-TRACK or mid-COOLDOWN returns to IDLE next cycle and kills any pending pulse from an in-flight `filt_strobe`.
- `frame_done` low: all state holds.

## Test plan
- Fill:
  - Stimulus: 4 valid frames, `cent_x`=100, `pix_count`=500.
  - Required: `filt_valid` rises 1 cycle after the 4th strobe with `filt_x`=100; `fsm_state` becomes TRACK 1 cycle later.
- Right swipe:
  - Stimulus: after fill at 100, frames 140, 180, 220, 260.
  - Required: `filt_x` = 110, 130, 160, 200. `swipe_right` pulses once, 2 cycles after the 260 frame; state then COOLDOWN. `swipe_left` stays 0.
- Left swipe and cooldown:
  - Stimulus: fill at 250, then 200, 150, 100, 50; then 15 more frames at 50 followed by a fast move right.
  - Required: one `swipe_left` after the 50 frame (`filt_x`=125 vs anchor 250). No pulse during the 15 cooldown frames. Returns to IDLE, then TRACK with anchor 50.
- Slow drift:
  - Stimulus: fill at 100, then +5 per frame for 24 frames.
  - Required: no swipe pulse. Anchor re-latched every 8 frames.
- Hand loss:
  - Stimulus: a frame with `pix_count`=150 during TRACK, then `cent_x`=400 with `pix_count`=500.
  - Required: `filt_valid`=0, `hand_present`=0, state IDLE after each. Four fresh valid frames are required before `filt_valid`.
- Reset:
  - Stimulus: assert `reset` on the same cycle as `filt_strobe` of the 260 frame in the right-swipe case.
  - Required: no `swipe_right`, all outputs 0, IDLE.

Source files
------------

// File: rtl/hand_swipe_detector_if.sv
// Per-frame centroid input and filtered-position / swipe output bundle of the
// hand swipe detector.
interface hand_swipe_detector_if;
  logic        frame_done;
  logic [9:0]  cent_x;
  logic [16:0] pix_count;
  logic [9:0]  filt_x;
  logic        filt_valid;
  logic        hand_present;
  logic        swipe_left;
  logic        swipe_right;
  logic [1:0]  fsm_state;

  modport master (
    output frame_done, cent_x, pix_count,
    input  filt_x, filt_valid, hand_present, swipe_left, swipe_right, fsm_state
  );

  modport slave (
    input  frame_done, cent_x, pix_count,
    output filt_x, filt_valid, hand_present, swipe_left, swipe_right, fsm_state
  );
endinterface

// File: rtl/hand_swipe_detector.sv
// Smooths the per-frame hand centroid with a power-of-two moving average and
// recognises left/right swipes against a periodically re-latched anchor.
module hand_swipe_detector #(
  parameter int AVG_LOG2        = 2,
  parameter int MIN_PIXELS      = 200,
  parameter int HOR_TOTAL       = 320,
  parameter int SWIPE_DIST      = 80,
  parameter int SWIPE_FRAMES    = 8,
  parameter int COOLDOWN_FRAMES = 15
) (
  input logic                  clock,
  input logic                  reset,
  hand_swipe_detector_if.slave bus
);

  localparam int W      = 1 << AVG_LOG2;
  localparam int SUM_W  = 10 + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  function automatic logic [9:0] avg_trunc(input logic [SUM_W-1:0] s);
    return 10'(s >> AVG_LOG2);
  endfunction

  logic [9:0]        hist_p0 [W];
  logic [SUM_W-1:0]  sum_p0;
  logic [SUM_W-1:0]  sum_next;
  logic [FILL_W-1:0] fill_p0;
  logic [FILL_W-1:0] fill_next;
  logic              frame_ok;

  logic [9:0]        filt_x_p1;
  logic              filt_valid_p1;
  logic              hand_present_p1;
  logic              vld_p1;

  state_t            state_p2;
  logic [9:0]        anchor_p2;
  logic [7:0]        frame_cnt_p2;
  logic [7:0]        cool_cnt_p2;
  logic              swipe_left_p2;
  logic              swipe_right_p2;

  logic [10:0]       filt_w;
  logic [10:0]       anchor_w;
  logic              move_right;
  logic              move_left;
  logic [7:0]        frame_cnt_inc;
  logic [7:0]        cool_cnt_inc;

  always_comb begin
    frame_ok  = (bus.pix_count >= 17'(MIN_PIXELS)) &&
                ({1'b0, bus.cent_x} < 11'(HOR_TOTAL));
    // Empty history slots hold 0, so subtracting the oldest slot is always safe.
    sum_next  = sum_p0 + SUM_W'(bus.cent_x) - SUM_W'(hist_p0[W-1]);
    fill_next = (fill_p0 == FILL_W'(W)) ? fill_p0 : fill_p0 + FILL_W'(1);
  end

  // ---- stage p0 -> p1: history, running sum, filtered position ----
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < W; i++) hist_p0[i] <= '0;
      sum_p0          <= '0;
      fill_p0         <= '0;
      filt_x_p1       <= '0;
      filt_valid_p1   <= 1'b0;
      hand_present_p1 <= 1'b0;
      vld_p1          <= 1'b0;
    end else begin
      vld_p1 <= bus.frame_done;
      if (bus.frame_done) begin
        if (frame_ok) begin
          hist_p0[0] <= bus.cent_x;
          for (int i = 1; i < W; i++) hist_p0[i] <= hist_p0[i-1];
          sum_p0          <= sum_next;
          fill_p0         <= fill_next;
          filt_x_p1       <= avg_trunc(sum_next);
          filt_valid_p1   <= (fill_next == FILL_W'(W));
          hand_present_p1 <= 1'b1;
        end else begin
          for (int i = 0; i < W; i++) hist_p0[i] <= '0;
          sum_p0          <= '0;
          fill_p0         <= '0;
          filt_valid_p1   <= 1'b0;
          hand_present_p1 <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    filt_w        = {1'b0, filt_x_p1};
    anchor_w      = {1'b0, anchor_p2};
    move_right    = filt_w >= anchor_w + 11'(SWIPE_DIST);
    move_left     = anchor_w >= filt_w + 11'(SWIPE_DIST);
    frame_cnt_inc = frame_cnt_p2 + 8'd1;
    cool_cnt_inc  = cool_cnt_p2 + 8'd1;
  end

  // ---- stage p1 -> p2: swipe FSM, advanced once per delayed frame strobe ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p2       <= IDLE;
      anchor_p2      <= '0;
      frame_cnt_p2   <= '0;
      cool_cnt_p2    <= '0;
      swipe_left_p2  <= 1'b0;
      swipe_right_p2 <= 1'b0;
    end else begin
      swipe_left_p2  <= 1'b0;
      swipe_right_p2 <= 1'b0;
      if (vld_p1) begin
        case (state_p2)
          IDLE: begin
            if (filt_valid_p1) begin
              anchor_p2    <= filt_x_p1;
              frame_cnt_p2 <= '0;
              state_p2     <= TRACK;
            end
          end
          TRACK: begin
            if (!filt_valid_p1) begin
              state_p2 <= IDLE;
            end else begin
              frame_cnt_p2 <= frame_cnt_inc;
              if (move_right) begin
                swipe_right_p2 <= 1'b1;
                cool_cnt_p2    <= '0;
                state_p2       <= COOLDOWN;
              end else if (move_left) begin
                swipe_left_p2 <= 1'b1;
                cool_cnt_p2   <= '0;
                state_p2      <= COOLDOWN;
              end else if (frame_cnt_inc == 8'(SWIPE_FRAMES)) begin
                // Slow drift: re-anchor so only fast motion counts as a swipe.
                anchor_p2    <= filt_x_p1;
                frame_cnt_p2 <= '0;
              end
            end
          end
          COOLDOWN: begin
            if (cool_cnt_inc == 8'(COOLDOWN_FRAMES)) begin
              cool_cnt_p2 <= '0;
              state_p2    <= IDLE;
            end else begin
              cool_cnt_p2 <= cool_cnt_inc;
            end
          end
          default: state_p2 <= IDLE;
        endcase
      end
    end
  end

  assign bus.filt_x       = filt_x_p1;
  assign bus.filt_valid   = filt_valid_p1;
  assign bus.hand_present = hand_present_p1;
  assign bus.swipe_left   = swipe_left_p2;
  assign bus.swipe_right  = swipe_right_p2;
  assign bus.fsm_state    = state_p2;

endmodule
